uart_frame_unpacker: RTL and testbench
======================================

Name: uart_frame_unpacker

Overview:
- Receive end of the ADC sample link.
- Deserialises the 8N1 UART byte stream that the ADC frame sender emits: 64 bytes per frame, carrying 32 12-bit samples.
- Rebuilds the samples in acquisition order and presents them one at a time with a valid strobe.
- Used on the host-side FPGA and in loopback self-test. Contains its own oversampling UART receiver, a frame assembler and an inter-byte timeout for resynchronisation.

Parameters:
- CLK_HZ, 50000000: sysclk frequency in Hz.
- BAUD, 115200: line rate. CLKS_PER_BIT = CLK_HZ/BAUD, integer division (434 at defaults).
- SAMPLES, 32: samples per frame. Bytes per frame = 2*SAMPLES.
- TIMEOUT_BITS, 20: idle bit-times allowed between bytes inside a frame.

Ports:
- sysclk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- enable  in  1  receive enable; low forces idle and discards any partial frame.
- rx  in  1  asynchronous UART serial input, idle high.
- sample_data  out  12  reassembled sample; holds its last value between strobes.
- sample_valid  out  1  one-cycle strobe; sample_data and sample_idx are valid.
- sample_idx  out  5  position of the sample in the frame, 0..SAMPLES-1.
- frame_done  out  1  one-cycle pulse, concurrent with sample_valid for the last sample.
- frame_err  out  1  one-cycle pulse; the partial frame has been discarded.
- busy  out  1  high while a byte or a partial frame is in progress.

Behaviour:
- Reset (rst=1 at a sysclk edge):
  - rx synchroniser flops go to 1; RX FSM goes to IDLE; all counters go to 0.
  - Outputs: sample_data=0, sample_valid=0, sample_idx=0, frame_done=0, frame_err=0, busy=0.
  - Reset mid-byte or mid-frame discards everything and does not pulse frame_err.
- Input sync: rx passes through two flops; only the synced value is used.
- RX FSM:
  - IDLE: synced rx=0 -> START, bit counter cleared.
  - START: at CLKS_PER_BIT/2 re-sample rx. rx=0 -> DATA; rx=1 -> IDLE (glitch rejected, no error).
  - DATA: sample every CLKS_PER_BIT clocks; 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT clocks.
    - rx=1 -> internal byte strobe on the next cycle, then IDLE.
    - rx=0 -> framing error: the byte is dropped, frame_err is pulsed, the assembler is cleared, and the FSM goes to BREAK.
  - BREAK: wait for synced rx=1, then IDLE.
- Frame format:
  - Byte 2k is the low byte of sample k (data[7:0]).
  - Byte 2k+1 is the high byte of sample k: {4'b0000, data[11:8]}.
  - Sample 0 is the first sample acquired.
- Assembler:
  - Tracks a phase bit (LOW/HIGH) and sample_idx. A byte in LOW stores it and sets phase to HIGH.
  - High byte with bits [7:4] != 0: frame_err pulse; phase=LOW, index=0; the sample is not emitted.
  - Otherwise, on the cycle after the byte strobe: sample_data={hi[3:0],lo}, sample_valid=1, sample_idx=current index.
    - Index increments, except when it is SAMPLES-1. In that case frame_done=1 in the same cycle, and index and phase clear.
  - Latency: sample_valid is asserted exactly 2 sysclk after the edge that samples the high byte's stop bit.
- Timeout:
  - Counts clocks while the RX FSM is IDLE and the assembler is mid-frame (phase=HIGH or index!=0).
  - Reaching TIMEOUT_BITS*CLKS_PER_BIT -> frame_err pulse; assembler cleared.
  - The count restarts on every start-bit detection.
- enable=0:
  - RX FSM forced to IDLE and assembler cleared on the next edge; no outputs are generated and no frame_err is pulsed.
  - On re-enable, the first valid byte is treated as sample 0 low.
- Simultaneous events: frame_err and sample_valid are never high together. An error on the final high byte yields frame_err only.
- busy = (RX FSM != IDLE) or assembler mid-frame.

Test Plan:
- Send 64 bytes encoding samples 0x000,0x001,...,0x01F at BAUD=115200 -> 32 sample_valid strobes with sample_idx 0..31 and matching data; frame_done together with idx 31 strobe; frame_err never high.
- Send low byte 0xAB, then high byte 0x3C -> sample_data=0xCAB is NOT emitted; frame_err pulses once; next pair 0xCD,0x0E -> sample_data=0xECD, sample_idx=0.
- Hold rx low through the stop-bit sample of byte 5 -> frame_err pulse; no strobe until rx returns high; next full frame decodes with idx starting at 0.
- Send 10 bytes, then idle for 25 bit-times -> frame_err pulse at 20*434 clocks after the last stop bit; following frame starts at idx 0.
- 0.3-bit-wide low glitch on idle rx -> no byte strobe, no error, busy returns to 0.
- Assert rst for one cycle mid-byte in sample 7 -> all outputs 0 next cycle; no frame_err; next full frame decodes correctly.

Source files
------------

// File: rtl/uart_frame_unpacker.sv
// ---------------------------------------------------------------------------
// uart_frame_unpacker
//   Receive end of the ADC sample link. Deserialises an 8N1 UART stream,
//   pairs bytes into 12-bit samples (low byte first, then {4'b0, hi nibble})
//   and presents them one at a time with sample_valid. A frame is SAMPLES
//   samples (2*SAMPLES bytes). An inter-byte timeout and framing/format
//   checks resynchronise the assembler to the start of a frame.
//
// Ports
//   sysclk        system clock, all logic on rising edge
//   rst           synchronous active-high reset
//   enable        receive enable; low idles the receiver, drops partial frame
//   rx            asynchronous serial input, idle high
//   sample_data   reassembled sample, held between strobes
//   sample_valid  one-cycle strobe for sample_data / sample_idx
//   sample_idx    sample position in frame, 0..SAMPLES-1
//   frame_done    one-cycle pulse alongside the last sample of a frame
//   frame_err     one-cycle pulse, partial frame discarded
//   busy          byte or partial frame in progress
// ---------------------------------------------------------------------------
module uart_frame_unpacker #(
    parameter int CLK_HZ       = 50000000,
    parameter int BAUD         = 115200,
    parameter int SAMPLES      = 32,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic        enable,
    input  logic        rx,
    output logic [11:0] sample_data,
    output logic        sample_valid,
    output logic [4:0]  sample_idx,
    output logic        frame_done,
    output logic        frame_err,
    output logic        busy
);

    localparam int CPB     = CLK_HZ / BAUD;
    localparam int HALF    = CPB / 2;
    localparam int TO_CLKS = TIMEOUT_BITS * CPB;
    localparam int CW      = $clog2(CPB + 1);
    localparam int TW      = $clog2(TO_CLKS + 1);

    localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [TW-1:0] TO_M1   = TW'(TO_CLKS - 1);
    localparam logic [4:0]    IDX_MAX = 5'(SAMPLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } rx_state_t;

    rx_state_t       state;
    logic            rx_meta, rx_sync;
    logic [CW-1:0]   clk_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic [7:0]      rx_byte;
    // [0]: stop bit accepted, [1]: byte strobe into the assembler
    logic [1:0]      vld_pipe;

    logic            phase_hi;
    logic [4:0]      idx;
    logic [7:0]      lo_byte;
    logic [TW-1:0]   to_cnt;

    logic            mid_frame;
    logic            stop_fail;
    logic            to_run;
    logic            to_fire;

    always_comb begin
        mid_frame = phase_hi | (idx != 5'd0);
        stop_fail = (state == S_STOP) && (clk_cnt == CPB_M1) && !rx_sync;
        // a low rx in IDLE is a start-bit detection and restarts the count
        to_run    = (state == S_IDLE) && mid_frame && rx_sync;
        to_fire   = to_run && (to_cnt == TO_M1);
    end

    // Bytes still in vld_pipe count as busy so busy does not dip between
    // the stop bit and the assembler update.
    assign busy = (state != S_IDLE) || mid_frame || (vld_pipe != 2'b00);

    always_ff @(posedge sysclk) begin
        if (rst) begin
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            state        <= S_IDLE;
            clk_cnt      <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            rx_byte      <= '0;
            vld_pipe     <= '0;
            phase_hi     <= 1'b0;
            idx          <= '0;
            lo_byte      <= '0;
            to_cnt       <= '0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            sample_idx   <= '0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_meta      <= rx;
            rx_sync      <= rx_meta;
            sample_valid <= 1'b0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            vld_pipe     <= {vld_pipe[0], 1'b0};

            if (!enable) begin
                state    <= S_IDLE;
                clk_cnt  <= '0;
                bit_cnt  <= '0;
                vld_pipe <= '0;
                phase_hi <= 1'b0;
                idx      <= '0;
                to_cnt   <= '0;
            end else begin
                // ---------------- receiver ----------------
                case (state)
                    S_IDLE: begin
                        if (!rx_sync) begin
                            state   <= S_START;
                            clk_cnt <= '0;
                            bit_cnt <= '0;
                        end
                    end
                    S_START: begin
                        if (clk_cnt == HALF_M1) begin
                            clk_cnt <= '0;
                            // still low at mid-bit: real start, else glitch
                            state   <= rx_sync ? S_IDLE : S_DATA;
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (clk_cnt == CPB_M1) begin
                            clk_cnt <= '0;
                            shreg   <= {rx_sync, shreg[7:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7)
                                state <= S_STOP;
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (clk_cnt == CPB_M1) begin
                            clk_cnt <= '0;
                            if (rx_sync) begin
                                rx_byte     <= shreg;
                                vld_pipe[0] <= 1'b1;
                                state       <= S_IDLE;
                            end else begin
                                state <= S_BREAK;
                            end
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end
                    S_BREAK: begin
                        if (rx_sync)
                            state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase

                // ---------------- timeout ----------------
                if (to_run && !to_fire)
                    to_cnt <= to_cnt + 1'b1;
                else
                    to_cnt <= '0;

                // ---------------- assembler ----------------
                if (stop_fail || to_fire) begin
                    frame_err <= 1'b1;
                    phase_hi  <= 1'b0;
                    idx       <= '0;
                end else if (vld_pipe[1]) begin
                    if (!phase_hi) begin
                        lo_byte  <= rx_byte;
                        phase_hi <= 1'b1;
                    end else if (rx_byte[7:4] != 4'h0) begin
                        // malformed high byte: drop the sample and resync
                        frame_err <= 1'b1;
                        phase_hi  <= 1'b0;
                        idx       <= '0;
                    end else begin
                        sample_data  <= {rx_byte[3:0], lo_byte};
                        sample_valid <= 1'b1;
                        sample_idx   <= idx;
                        phase_hi     <= 1'b0;
                        if (idx == IDX_MAX) begin
                            frame_done <= 1'b1;
                            idx        <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_unpacker.sv
module tb_uart_frame_unpacker;

    localparam int CLK_HZ  = 1600000;
    localparam int BAUD    = 100000;
    localparam int CPB     = CLK_HZ / BAUD;   // 16 clocks per bit
    localparam int TO_BITS = 20;
    localparam int TO_CLKS = TO_BITS * CPB;

    logic        sysclk = 1'b0;
    logic        rst;
    logic        enable;
    logic        rx;
    logic [11:0] sample_data;
    logic        sample_valid;
    logic [4:0]  sample_idx;
    logic        frame_done;
    logic        frame_err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        err;
        logic [11:0] data;
        logic [4:0]  idx;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    uart_frame_unpacker #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .SAMPLES(32), .TIMEOUT_BITS(TO_BITS)
    ) dut (
        .sysclk(sysclk), .rst(rst), .enable(enable), .rx(rx),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_idx(sample_idx), .frame_done(frame_done),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic err, input logic [11:0] d, input logic [4:0] i, input logic dn);
        exp_t e;
        e.err = err; e.data = d; e.idx = i; e.done = dn;
        exp_q.push_back(e);
    endtask

    task automatic bits(input int n);
        repeat (n * CPB) @(negedge sysclk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        bits(1);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            bits(1);
        end
        rx = stop_bit;
        bits(1);
        if (stop_bit) rx = 1'b1;
    endtask

    task automatic send_sample(input logic [11:0] s);
        send_byte(s[7:0], 1'b1);
        send_byte({4'h0, s[11:8]}, 1'b1);
    endtask

    // full frame of samples base, base+1, ..., base+31
    task automatic send_frame(input logic [11:0] base);
        logic [11:0] s;
        for (int k = 0; k < 32; k++) begin
            s = base + 12'(k);
            push(1'b0, s, 5'(k), k == 31);
            send_sample(s);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_data"},  32'(sample_data), 0);
        chk({tag, "_valid"}, 32'(sample_valid), 0);
        chk({tag, "_idx"},   32'(sample_idx), 0);
        chk({tag, "_done"},  32'(frame_done), 0);
        chk({tag, "_err"},   32'(frame_err), 0);
        chk({tag, "_busy"},  32'(busy), 0);
    endtask

    // Monitor: every output event is matched against the scoreboard head.
    always @(negedge sysclk) begin
        if (!rst && (sample_valid || frame_err || frame_done)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {29'd0, sample_valid, frame_err, frame_done}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("event_is_err",   32'(frame_err), 32'(mon_e.err));
                chk("event_is_valid", 32'(sample_valid), 32'(!mon_e.err));
                if (!mon_e.err) begin
                    chk("sample_data", 32'(sample_data), 32'(mon_e.data));
                    chk("sample_idx",  32'(sample_idx), 32'(mon_e.idx));
                    chk("frame_done",  32'(frame_done), 32'(mon_e.done));
                end else begin
                    chk("done_with_err", 32'(frame_done), 0);
                end
            end
        end
    end

    initial begin
        repeat (90000) @(posedge sysclk);
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; enable = 1'b1; rx = 1'b1;
        repeat (3) @(negedge sysclk);
        chk_outputs_zero("reset");
        rst = 1'b0;
        bits(2);

        // 1: ramp frame 0x000..0x01F
        send_frame(12'h000);
        bits(2);

        // 2: bad high byte, then a good pair, then the leftover idx triggers timeout
        push(1'b1, 12'h0, 5'd0, 1'b0);
        send_byte(8'hAB, 1'b1);
        send_byte(8'h3C, 1'b1);
        push(1'b0, 12'hECD, 5'd0, 1'b0);
        send_sample(12'hECD);
        push(1'b1, 12'h0, 5'd0, 1'b0);
        repeat (TO_CLKS + 4 * CPB) @(negedge sysclk);
        chk("busy_after_timeout", 32'(busy), 0);

        // 3: framing error on byte 5 with rx held low
        push(1'b0, 12'h321, 5'd0, 1'b0);
        send_sample(12'h321);
        push(1'b0, 12'h654, 5'd1, 1'b0);
        send_sample(12'h654);
        send_byte(8'h87, 1'b1);
        push(1'b1, 12'h0, 5'd0, 1'b0);
        send_byte(8'h09, 1'b0);
        bits(3);
        chk("busy_in_break", 32'(busy), 1);
        rx = 1'b1;
        bits(2);
        send_frame(12'h7E0);
        bits(2);

        // 4: 10 bytes then idle: timeout
        for (int k = 0; k < 5; k++) begin
            push(1'b0, 12'hA00 + 12'(k), 5'(k), 1'b0);
            send_sample(12'hA00 + 12'(k));
        end
        push(1'b1, 12'h0, 5'd0, 1'b0);
        n = 0;
        while (!frame_err && n < 2 * TO_CLKS) begin
            @(negedge sysclk);
            n++;
        end
        chk("timeout_in_window", 32'(n >= TO_CLKS - CPB && n <= TO_CLKS + CPB), 1);
        bits(5);

        // 5: short glitch on idle line
        rx = 1'b0;
        repeat (5) @(negedge sysclk);
        rx = 1'b1;
        bits(2);
        chk("busy_after_glitch", 32'(busy), 0);

        // 6: enable drop mid-frame discards silently
        for (int k = 0; k < 3; k++) begin
            push(1'b0, 12'h155 + 12'(k), 5'(k), 1'b0);
            send_sample(12'h155 + 12'(k));
        end
        chk("busy_mid_frame", 32'(busy), 1);
        enable = 1'b0;
        repeat (3) @(negedge sysclk);
        chk("busy_disabled", 32'(busy), 0);
        enable = 1'b1;
        bits(1);
        send_frame(12'hF00);
        bits(2);

        // 7: reset mid-byte in sample 7
        for (int k = 0; k < 7; k++) begin
            push(1'b0, 12'h040 + 12'(k), 5'(k), 1'b0);
            send_sample(12'h040 + 12'(k));
        end
        send_byte(8'h47, 1'b1);
        rx = 1'b0;
        bits(1);
        rx = 1'b1;
        bits(2);
        rst = 1'b1;
        @(negedge sysclk);
        rst = 1'b0;
        chk_outputs_zero("midreset");
        bits(12);
        send_frame(12'h8C3);
        bits(TO_BITS + 4);

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
